// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer, config register and FWFT byte FIFO with sticky errors
module uart_rx_ctrl #(
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [6:0]  cfg_data,
  input  logic        host_rd,
  input  logic        err_clr,
  input  logic        RXRDY,
  input  logic [7:0]  UART_RDATA,
  input  logic [2:0]  RX_STATUS,
  output logic        read,
  output logic [19:0] max,
  output logic        EIGHT,
  output logic        PEN,
  output logic        OHEL,
  output logic [7:0]  host_data,
  output logic        host_empty,
  output logic        host_full,
  output logic [3:0]  err,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
  state_t state;
  logic [6:0] cfg;
  logic [7:0] mem [2**AW];
  logic [AW:0] wp, rp;
  logic cap, pop, push, ovr, empty, full;
  function automatic logic [19:0] baud(input logic [3:0] s);
    case (s)
      4'd0: baud = 20'd333333;
      4'd1: baud = 20'd83333;
      4'd2: baud = 20'd41667;
      4'd3: baud = 20'd20833;
      4'd4: baud = 20'd10417;
      4'd5: baud = 20'd5208;
      4'd6: baud = 20'd2604;
      4'd7: baud = 20'd1736;
      4'd9: baud = 20'd434;
      4'd10: baud = 20'd217;
      4'd11: baud = 20'd109;
      default: baud = 20'd868;
    endcase
  endfunction
  assign EIGHT = cfg[2];
  assign PEN = cfg[1];
  assign OHEL = cfg[0];
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign cap = state == IDLE && RXRDY;
  assign pop = host_rd && !empty;
  assign push = cap && (!full || pop);
  assign ovr = cap && full && !pop;
  assign host_empty = empty;
  assign host_full = full;
  assign host_data = empty ? 8'h00 : mem[rp[AW-1:0]];
  assign irq = !empty || |err;
  always_ff @(posedge clk)
    if (!rst && !cfg_wr && push) mem[wp[AW-1:0]] <= UART_RDATA;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      read <= 1'b0;
      cfg <= 7'b0100_1_0_0;
      max <= 20'd10417;
      wp <= '0;
      rp <= '0;
      err <= '0;
    end else begin
      state <= cap ? ACK : state == ACK ? WAIT : (state == WAIT && !RXRDY) ? IDLE : state;
      read <= cap;
      max <= baud(cfg[6:3]);
      if (cfg_wr) begin
        cfg <= cfg_data;
        wp <= '0;
        rp <= '0;
        err <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        err <= (err & {4{~err_clr}}) | {ovr, cap ? RX_STATUS : 3'b000};
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized and directed checks of uart_rx_ctrl against a queue-based model
module tb_uart_rx_ctrl;
  logic clk = 0, rst = 1, cfg_wr = 0, host_rd = 0, err_clr = 0, RXRDY = 0;
  logic [6:0] cfg_data = '0;
  logic [7:0] UART_RDATA = '0;
  logic [2:0] RX_STATUS = '0;
  logic read, EIGHT, PEN, OHEL, host_empty, host_full, irq;
  logic [19:0] max;
  logic [7:0] host_data;
  logic [3:0] err;
  int vectors = 0, miscompares = 0, rd_cnt = 0;
  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_data(cfg_data), .host_rd(host_rd),
    .err_clr(err_clr), .RXRDY(RXRDY), .UART_RDATA(UART_RDATA), .RX_STATUS(RX_STATUS),
    .read(read), .max(max), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .host_data(host_data),
    .host_empty(host_empty), .host_full(host_full), .err(err), .irq(irq)
  );
  always #5 clk = ~clk;
  int unsigned btab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                             868, 434, 217, 109, 868, 868, 868, 868};
  logic [7:0] q [$];
  logic [3:0] merr;
  logic [6:0] mcfg;
  int unsigned mmax;
  bit busy, mread, started = 0, m_cap, m_pop, m_ovr;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      merr = 0;
      mcfg = 7'b0100100;
      mmax = 10417;
      busy = 0;
      mread = 0;
      started = 1;
    end else begin
      m_cap = !busy && RXRDY;
      m_pop = host_rd && q.size() > 0;
      mmax = btab[mcfg[6:3]];
      if (!m_cap && busy && !mread && !RXRDY) busy = 0;
      if (m_cap) busy = 1;
      mread = m_cap;
      if (cfg_wr) begin
        q.delete();
        merr = 0;
        mcfg = cfg_data;
      end else begin
        if (m_pop) void'(q.pop_front());
        m_ovr = 0;
        if (m_cap) begin
          if (q.size() < 8) q.push_back(UART_RDATA);
          else m_ovr = 1;
        end
        merr = (err_clr ? 4'b0 : merr) | {m_ovr, m_cap ? RX_STATUS : 3'b0};
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (started && !rst) begin
    if (read) rd_cnt++;
    chk("read", 32'(read), 32'(mread));
    chk("max", 32'(max), mmax);
    chk("cfg_bits", {29'b0, EIGHT, PEN, OHEL}, {29'b0, mcfg[2:0]});
    chk("host_empty", 32'(host_empty), 32'(q.size() == 0));
    chk("host_full", 32'(host_full), 32'(q.size() == 8));
    chk("host_data", 32'(host_data), q.size() > 0 ? 32'(q[0]) : 32'h0);
    chk("err", 32'(err), 32'(merr));
    chk("irq", 32'(irq), 32'(q.size() > 0 || merr != 0));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic [2:0] st, input int hold, input bit rd, input bit ec);
    RXRDY = 1;
    UART_RDATA = b;
    RX_STATUS = st;
    host_rd = rd;
    err_clr = ec;
    tick();
    host_rd = 0;
    err_clr = 0;
    repeat (hold - 1) tick();
    RXRDY = 0;
    RX_STATUS = 0;
    tick();
    tick();
  endtask
  task automatic pop1();
    host_rd = 1;
    tick();
    host_rd = 0;
  endtask
  initial begin
    int r0, hold;
    repeat (2) tick();
    rst = 0;
    tick();
    chk("rst_max", 32'(max), 32'd10417);
    chk("rst_cfg", {29'b0, EIGHT, PEN, OHEL}, 32'b100);
    chk("rst_empty", 32'(host_empty), 32'd1);
    chk("rst_err_irq_read", {27'b0, err, irq, read}, 32'd0);
    cfg_wr = 1;
    cfg_data = 7'b1000_0_1_1;
    tick();
    cfg_wr = 0;
    tick();
    chk("cfg_max", 32'(max), 32'd868);
    chk("cfg_bits", {29'b0, EIGHT, PEN, OHEL}, 32'b011);
    r0 = rd_cnt;
    send(8'hA5, 3'b000, 10, 0, 0);
    chk("a5_one_read", 32'(rd_cnt - r0), 32'd1);
    chk("a5_data", 32'(host_data), 32'hA5);
    chk("a5_irq", {30'b0, host_empty, irq}, 32'b01);
    pop1();
    chk("a5_popped", 32'(host_empty), 32'd1);
    for (int i = 1; i <= 8; i++) send(8'(i), 3'b000, 2, 0, 0);
    r0 = rd_cnt;
    send(8'h09, 3'b000, 2, 0, 0);
    chk("ovr_read", 32'(rd_cnt - r0), 32'd1);
    chk("ovr_full", 32'(host_full), 32'd1);
    chk("ovr_err", 32'(err), 32'b1000);
    for (int i = 1; i <= 8; i++) begin
      chk("drain1", 32'(host_data), 32'(i));
      pop1();
    end
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clr1", 32'(err), 32'd0);
    for (int i = 1; i <= 8; i++) send(8'(i), 3'b000, 2, 0, 0);
    send(8'h09, 3'b000, 2, 1, 0);
    chk("pp_err", 32'(err), 32'd0);
    for (int i = 2; i <= 9; i++) begin
      chk("drain2", 32'(host_data), 32'(i));
      pop1();
    end
    send(8'h5C, 3'b011, 1, 0, 1);
    chk("set_wins", 32'(err), 32'b0011);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clr2", 32'(err), 32'd0);
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) RXRDY = 0;
      end else if (!RXRDY && $urandom_range(3) == 0) begin
        RXRDY = 1;
        UART_RDATA = 8'($urandom);
        RX_STATUS = $urandom_range(7) == 0 ? 3'($urandom) : 3'b0;
        hold = $urandom_range(1, 6);
      end
      host_rd = $urandom_range(c < 2000 ? 9 : 1) == 0;
      err_clr = $urandom_range(19) == 0;
      cfg_wr = $urandom_range(149) == 0;
      cfg_data = 7'($urandom);
      tick();
    end
    RXRDY = 0;
    host_rd = 0;
    err_clr = 0;
    cfg_wr = 0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencer and configuration block for the UART receiver datapath. It drives the receiver's baud/frame configuration (max, EIGHT, PEN, OHEL) from a host-written config register. It acknowledges each received byte with a one-cycle read pulse and buffers bytes into a small first-word-fall-through FIFO with sticky error capture. It sits between the receiver and the host/processor bus and raises an interrupt when data or errors are pending.

Parameters:
AW, 3, FIFO address width; FIFO depth = 2**AW (8 entries)

Ports:
clk  input  1  system clock (100 MHz; baud table below assumes this)
rst  input  1  reset
cfg_wr  input  1  one-cycle strobe, load cfg_data into config register
cfg_data  input  7  {baud_sel[3:0], eight, pen, ohel}
host_rd  input  1  one-cycle strobe, pop FIFO head
err_clr  input  1  one-cycle strobe, clear sticky errors
RXRDY  input  1  receiver has a byte available
UART_RDATA  input  8  receiver data byte
RX_STATUS  input  3  receiver status: [0] parity err, [1] framing err, [2] receiver overrun
read  output  1  one-cycle acknowledge pulse to receiver
max  output  20  bit-time count to receiver
EIGHT  output  1  8-bit frame select to receiver
PEN  output  1  parity enable to receiver
OHEL  output  1  odd/even parity select to receiver
host_data  output  8  FIFO head byte (valid when host_empty=0)
host_empty  output  1  FIFO empty
host_full  output  1  FIFO full
err  output  4  sticky {fifo_ovr, rx_ovr, framing, parity}
irq  output  1  ~host_empty | (|err)

Behaviour:
- Reset: synchronous, active-high; one clock, rst, sampled on rising edge of clk.
- Reset values: baud_sel=4, EIGHT=1, PEN=0, OHEL=0, max=10417, read=0, FIFO empty (host_empty=1, host_full=0, host_data=0), err=0, irq=0, state=IDLE.
- Baud decode (registered, updates the cycle after the config register):
  - 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208, 6:2604, 7:1736, 8:868, 9:434, 10:217, 11:109.
  - 12-15 decode to 868.
- cfg_wr: config register loads next edge. The same edge flushes the FIFO and clears err. If the sequencer is in ACK or WAIT, the sequence completes normally. A byte captured on that same edge is discarded.
- Sequencer FSM:
  - IDLE: on RXRDY=1, capture UART_RDATA and RX_STATUS, then go to ACK.
  - ACK: read=1 for exactly this cycle, then go to WAIT.
  - WAIT: stay until RXRDY=0, then go to IDLE.
  - Minimum 3 cycles per byte. RXRDY held high never produces a second read pulse.
- Capture/push:
  - On the IDLE->ACK edge, push the byte if the FIFO is not full.
  - If the FIFO is full and no pop occurs that cycle, drop the byte and set err[3].
  - Push and pop in the same cycle when full: the pop frees a slot, the push succeeds, no overrun.
  - Status bits OR into err[0..2] whether or not the byte was stored.
- FIFO:
  - First-word-fall-through: host_data is the head combinationally from storage.
  - Pointers are AW+1 bits and wrap naturally.
  - host_rd while empty is ignored (no pointer change, no error).
  - Pop and push on an empty FIFO in the same cycle: the push occurs, the pop is ignored.
- err:
  - Each bit is sticky until err_clr or cfg_wr.
  - err_clr in the same cycle as a new error sets that error (set wins).
- irq is combinational from registered state.

Test Plan:
- Reset with rst=1 for 2 cycles -> max=10417, EIGHT=1, PEN=0, OHEL=0, host_empty=1, err=0, irq=0, read=0.
- cfg_wr with cfg_data=7'b1000_0_1_1 -> after 2 edges max=868, EIGHT=0, PEN=1, OHEL=1; any FIFO contents are flushed.
- Assert RXRDY with UART_RDATA=8'hA5, RX_STATUS=0, held 10 cycles -> exactly one read pulse 1 cycle after capture; host_data=8'hA5, host_empty=0, irq=1. Then host_rd -> host_empty=1.
- Push 8 bytes 8'h01..8'h08, then a 9th byte 8'h09 with no pop -> host_full=1, err[3]=1, read still pulsed; pops return 01..08 in order.
- 9th byte arrives with host_rd on the capture cycle while full -> err[3]=0; final drain order is 02..09.
- Byte with RX_STATUS=3'b011 and err_clr asserted on the same cycle -> err=4'b0011. A later err_clr alone -> err=0.
